// File: rtl/dpram_param.sv
// Parametrised dual-port block RAM: one write port, one read port, byte-lane enables, selectable collision policy.
// Latency 1 cycle (mode[0]=0) or 2 cycles (mode[0]=1); no backpressure, so a read is accepted every cycle.
module dpram_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [BE_WIDTH-1:0]   be,
   input  logic                  wen,
   input  logic                  ren,
   input  logic [1:0]            mode,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rvalid
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  waddr_ok;
   logic                  raddr_ok;
   logic                  wr_act;
   logic                  collide;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] s1_dat;
   logic                  s1_vld;

   assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
   assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
   assign wr_act   = wen && !rst && waddr_ok;
   assign collide  = wr_act && (raddr == waddr);

   // Array contents survive reset; only the read pipeline is cleared.
   always_ff @(posedge clk) begin
      if (wr_act) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
               mem[waddr[IDX_W-1:0]][8*i +: 8] <= data_in[8*i +: 8];
            end
         end
      end
   end

   // Write-first merges the incoming enabled lanes over the stored word.
   always_comb begin
      rd_word = '0;
      if (raddr_ok) begin
         rd_word = mem[raddr[IDX_W-1:0]];
         if (collide && mode[1]) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
               if (be[i]) begin
                  rd_word[8*i +: 8] = data_in[8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_dat   <= '0;
         s1_vld   <= 1'b0;
         data_out <= '0;
         rvalid   <= 1'b0;
      end else begin
         s1_vld <= ren && mode[0];
         if (ren && mode[0]) begin
            s1_dat <= rd_word;
         end
         if (mode[0]) begin
            rvalid <= s1_vld;
            if (s1_vld) begin
               data_out <= s1_dat;
            end
         end else begin
            rvalid <= ren;
            if (ren) begin
               data_out <= rd_word;
            end
         end
      end
   end

endmodule
